// File: rtl/glitch_sequencer_pkg.sv
// glitch_sequencer_pkg: one-hot state encodings and default timeout for the glitch sequencer
package glitch_sequencer_pkg;
   localparam int GLITCH_SEQ_TIMEOUT = 1024;
   typedef enum logic [5:0] {
      GLITCH_SEQ_IDLE     = 6'b000001,
      GLITCH_SEQ_RST_REQ  = 6'b000010,
      GLITCH_SEQ_RST_WAIT = 6'b000100,
      GLITCH_SEQ_DELAY    = 6'b001000,
      GLITCH_SEQ_GLITCH   = 6'b010000,
      GLITCH_SEQ_DONE     = 6'b100000
   } state_e;
endpackage

// File: rtl/glitch_sequencer_if.sv
// glitch_sequencer_if: host command, reset-stage and glitch-driver signals of the sequencer
interface glitch_sequencer_if #(
   parameter int DELAY_W = 32,
   parameter int WIDTH_W = 16
);
   logic start;
   logic abort;
   logic [DELAY_W-1:0] delay;
   logic [WIDTH_W-1:0] width;
   logic tgt_rst_n;
   logic rst_en;
   logic glitch_o;
   logic busy;
   logic done;
   logic err;
   modport master (
      output start, abort, delay, width, tgt_rst_n,
      input  rst_en, glitch_o, busy, done, err
   );
   modport slave (
      input  start, abort, delay, width, tgt_rst_n,
      output rst_en, glitch_o, busy, done, err
   );
endinterface

// File: rtl/glitch_sequencer_cnt.sv
// glitch_cnt: loadable down-counter with zero flag
module glitch_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] load_val,
   output logic         zero
);
   logic [W-1:0] cnt_d, cnt_q;
   always_comb cnt_d = load ? load_val : en ? cnt_q - W'(1) : cnt_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt_q <= '0;
      else cnt_q <= cnt_d;
   assign zero = cnt_q == '0;
endmodule

// File: rtl/glitch_sequencer.sv
// glitch_sequencer: reset-request, release wait, programmable delay and glitch pulse sequencer
module glitch_sequencer
   import glitch_sequencer_pkg::*;
#(
   parameter int DELAY_W = 32,
   parameter int WIDTH_W = 16,
   parameter int TIMEOUT = GLITCH_SEQ_TIMEOUT
) (
   input logic clk_in,
   input logic rst,
   glitch_sequencer_if.slave bus
);
   localparam int TO_W = $clog2(TIMEOUT);
   state_e state_d, state_q;
   logic err_d, err_q;
   logic [DELAY_W-1:0] dly_d, dly_q;
   logic [WIDTH_W-1:0] wid_d, wid_q;
   logic to_load, to_en, to_zero;
   logic dly_load, dly_en, dly_zero;
   logic wid_load, wid_en, wid_zero;
   logic dly_nz, wid_nz;
   assign dly_nz = dly_q != '0;
   assign wid_nz = wid_q != '0;
   always_comb begin
      state_d = state_q;
      err_d = err_q;
      dly_d = dly_q;
      wid_d = wid_q;
      to_load = 1'b0;
      to_en = 1'b0;
      dly_load = 1'b0;
      dly_en = 1'b0;
      wid_load = 1'b0;
      wid_en = 1'b0;
      // abort outranks every other transition, timeout included
      if (state_q != GLITCH_SEQ_IDLE && bus.abort) state_d = GLITCH_SEQ_IDLE;
      else
         case (state_q)
            GLITCH_SEQ_IDLE:
               if (bus.start) begin
                  state_d = GLITCH_SEQ_RST_REQ;
                  err_d = 1'b0;
                  dly_d = bus.delay;
                  wid_d = bus.width;
               end
            GLITCH_SEQ_RST_REQ: begin
               state_d = GLITCH_SEQ_RST_WAIT;
               to_load = 1'b1;
            end
            GLITCH_SEQ_RST_WAIT:
               if (bus.tgt_rst_n) begin
                  state_d = dly_nz ? GLITCH_SEQ_DELAY : wid_nz ? GLITCH_SEQ_GLITCH : GLITCH_SEQ_DONE;
                  dly_load = dly_nz;
                  wid_load = !dly_nz && wid_nz;
               end else if (to_zero) begin
                  state_d = GLITCH_SEQ_IDLE;
                  err_d = 1'b1;
               end else to_en = 1'b1;
            GLITCH_SEQ_DELAY:
               if (dly_zero) begin
                  state_d = wid_nz ? GLITCH_SEQ_GLITCH : GLITCH_SEQ_DONE;
                  wid_load = wid_nz;
               end else dly_en = 1'b1;
            GLITCH_SEQ_GLITCH:
               if (wid_zero) state_d = GLITCH_SEQ_DONE;
               else wid_en = 1'b1;
            default: state_d = GLITCH_SEQ_IDLE;
         endcase
   end
   always_ff @(posedge clk_in or posedge rst)
      if (rst) begin
         state_q <= GLITCH_SEQ_IDLE;
         err_q <= 1'b0;
         dly_q <= '0;
         wid_q <= '0;
      end else begin
         state_q <= state_d;
         err_q <= err_d;
         dly_q <= dly_d;
         wid_q <= wid_d;
      end
   // counters hold n-1 so a phase of n cycles ends on the zero flag
   glitch_cnt #(.W(TO_W)) u_to (
      .clk(clk_in), .rst(rst), .load(to_load), .en(to_en),
      .load_val(TO_W'(TIMEOUT - 1)), .zero(to_zero)
   );
   glitch_cnt #(.W(DELAY_W)) u_dly (
      .clk(clk_in), .rst(rst), .load(dly_load), .en(dly_en),
      .load_val(dly_q - DELAY_W'(1)), .zero(dly_zero)
   );
   glitch_cnt #(.W(WIDTH_W)) u_wid (
      .clk(clk_in), .rst(rst), .load(wid_load), .en(wid_en),
      .load_val(wid_q - WIDTH_W'(1)), .zero(wid_zero)
   );
   assign bus.rst_en = state_q == GLITCH_SEQ_RST_REQ;
   assign bus.glitch_o = state_q == GLITCH_SEQ_GLITCH;
   assign bus.busy = state_q != GLITCH_SEQ_IDLE;
   assign bus.done = state_q == GLITCH_SEQ_DONE;
   assign bus.err = err_q;
endmodule

// File: tb/tb_glitch_sequencer.sv
// tb_glitch_sequencer: directed vector table plus async-reset sequences for glitch_sequencer
module tb_glitch_sequencer;
   typedef struct {
      int rst_first;
      int rst_cnt;
      int gl_first;
      int gl_cnt;
      int done_first;
      int done_cnt;
      int idle_first;
      int err_c1;
      int err;
   } obs_t;
   typedef struct {
      int d;
      int w;
      int len;
      int ab;
      int st2;
      int ncyc;
      obs_t e;
   } vec_t;
   logic clk_in = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int errors = 0;
   bit stage_on = 1'b0;
   int stage_len = 0;
   int rcnt = 0;
   vec_t v[14];
   obs_t o;
   glitch_sequencer_if #(.DELAY_W(32), .WIDTH_W(16)) bus();
   glitch_sequencer #(.DELAY_W(32), .WIDTH_W(16), .TIMEOUT(1024)) dut (
      .clk_in(clk_in), .rst(rst), .bus(bus)
   );
   always #5 clk_in = ~clk_in;
   // reset stage model: holds the target low for stage_len cycles after rst_en
   always @(negedge clk_in)
      if (!stage_on) bus.tgt_rst_n = 1'b0;
      else if (bus.rst_en) begin
         bus.tgt_rst_n = 1'b0;
         rcnt = stage_len;
      end else if (rcnt > 0) begin
         rcnt--;
         if (rcnt == 0) bus.tgt_rst_n = 1'b1;
      end
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   task automatic run(input vec_t t, output obs_t r);
      r = '{default: 0};
      stage_on = t.len >= 0;
      stage_len = t.len;
      @(negedge clk_in);
      bus.delay = 32'(t.d);
      bus.width = 16'(t.w);
      bus.start = 1'b1;
      for (int c = 1; c <= t.ncyc; c++) begin
         @(negedge clk_in);
         if (c == 1) r.err_c1 = int'(bus.err);
         if (bus.rst_en) begin if (r.rst_cnt == 0) r.rst_first = c; r.rst_cnt++; end
         if (bus.glitch_o) begin if (r.gl_cnt == 0) r.gl_first = c; r.gl_cnt++; end
         if (bus.done) begin if (r.done_cnt == 0) r.done_first = c; r.done_cnt++; end
         if (!bus.busy && r.idle_first == 0) r.idle_first = c;
         bus.start = c == t.st2;
         bus.abort = c == t.ab;
         if (c == 1) begin
            bus.delay = 32'd2;
            bus.width = 16'd1;
         end
      end
      bus.start = 1'b0;
      bus.abort = 1'b0;
      r.err = int'(bus.err);
   endtask
   task automatic cmp(input string t, input obs_t a, input obs_t e);
      chk({t, ".rst_first"}, a.rst_first, e.rst_first);
      chk({t, ".rst_cnt"}, a.rst_cnt, e.rst_cnt);
      chk({t, ".gl_first"}, a.gl_first, e.gl_first);
      chk({t, ".gl_cnt"}, a.gl_cnt, e.gl_cnt);
      chk({t, ".done_first"}, a.done_first, e.done_first);
      chk({t, ".done_cnt"}, a.done_cnt, e.done_cnt);
      chk({t, ".idle_first"}, a.idle_first, e.idle_first);
      chk({t, ".err_c1"}, a.err_c1, e.err_c1);
      chk({t, ".err"}, a.err, e.err);
   endtask
   initial begin
      v[0]  = '{10, 5, 255, 0, 0, 280, '{1, 1, 267, 5, 272, 1, 273, 0, 0}};
      v[1]  = '{0, 3, 20, 0, 0, 32, '{1, 1, 22, 3, 25, 1, 26, 0, 0}};
      v[2]  = '{4, 0, 20, 0, 0, 32, '{1, 1, 0, 0, 26, 1, 27, 0, 0}};
      v[3]  = '{1, 1, 5, 0, 0, 16, '{1, 1, 8, 1, 9, 1, 10, 0, 0}};
      v[4]  = '{0, 0, 3, 0, 0, 12, '{1, 1, 0, 0, 5, 1, 6, 0, 0}};
      v[5]  = '{3, 2, 1, 0, 0, 14, '{1, 1, 6, 2, 8, 1, 9, 0, 0}};
      v[6]  = '{2, 8, 5, 10, 0, 24, '{1, 1, 9, 2, 0, 0, 11, 0, 0}};
      v[7]  = '{6, 4, 5, 9, 0, 24, '{1, 1, 0, 0, 0, 0, 10, 0, 0}};
      v[8]  = '{2, 2, 20, 5, 0, 30, '{1, 1, 0, 0, 0, 0, 6, 0, 0}};
      v[9]  = '{10, 5, 5, 0, 10, 30, '{1, 1, 17, 5, 22, 1, 23, 0, 0}};
      v[10] = '{3, 3, -1, 1025, 0, 1030, '{1, 1, 0, 0, 0, 0, 1026, 0, 0}};
      v[11] = '{3, 3, -1, 0, 0, 1030, '{1, 1, 0, 0, 0, 0, 1026, 0, 1}};
      v[12] = '{2, 2, 4, 0, 0, 16, '{1, 1, 8, 2, 10, 1, 11, 0, 0}};
      v[13] = '{3, 3, -1, 0, 0, 1030, '{1, 1, 0, 0, 0, 0, 1026, 0, 1}};
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.delay = '0;
      bus.width = '0;
      repeat (2) @(negedge clk_in);
      chk("reset.rst_en", int'(bus.rst_en), 0);
      chk("reset.glitch_o", int'(bus.glitch_o), 0);
      chk("reset.busy", int'(bus.busy), 0);
      chk("reset.done", int'(bus.done), 0);
      chk("reset.err", int'(bus.err), 0);
      rst = 1'b0;
      for (int i = 0; i < 14; i++) begin
         run(v[i], o);
         cmp($sformatf("v%0d", i), o, v[i].e);
      end
      @(negedge clk_in);
      chk("arst_idle.err_before", int'(bus.err), 1);
      #2 rst = 1'b1;
      #1 chk("arst_idle.err", int'(bus.err), 0);
      @(negedge clk_in) rst = 1'b0;
      stage_on = 1'b1;
      stage_len = 2;
      bus.delay = 32'd0;
      bus.width = 16'd8;
      bus.start = 1'b1;
      @(negedge clk_in) bus.start = 1'b0;
      repeat (4) @(negedge clk_in);
      chk("arst_glitch.glitch_before", int'(bus.glitch_o), 1);
      #2 rst = 1'b1;
      #1 begin
         chk("arst_glitch.glitch_o", int'(bus.glitch_o), 0);
         chk("arst_glitch.busy", int'(bus.busy), 0);
         chk("arst_glitch.err", int'(bus.err), 0);
      end
      @(negedge clk_in) rst = 1'b0;
      repeat (2) @(negedge clk_in);
      chk("arst_after.busy", int'(bus.busy), 0);
      chk("arst_after.glitch_o", int'(bus.glitch_o), 0);
      run(v[3], o);
      cmp("post_rst", o, v[3].e);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
